// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external adder among NUM_REQ requesters.
module adder_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic                     resp_ovf,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_cout,
  input  logic                     add_ovf,
  output logic                     busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NR = (PW+1)'(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, gnt, gnt_q;
  logic found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic sel_sub;
  function automatic logic [PW-1:0] wrap(input logic [PW:0] v);
    return (v >= NR) ? PW'(v - NR) : PW'(v);
  endfunction
  // Scan from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    gnt = rr_ptr;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[wrap({1'b0, rr_ptr} + (PW+1)'(k))]) begin
        gnt = wrap({1'b0, rr_ptr} + (PW+1)'(k));
        found = 1'b1;
      end
  end
  assign sel_a = req_a[int'(gnt) * WIDTH +: WIDTH];
  assign sel_b = req_b[int'(gnt) * WIDTH +: WIDTH];
  assign sel_sub = req_sub[gnt];
  assign req_ready = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << gnt : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt_q <= '0;
      resp_valid <= '0;
      resp_sum <= '0;
      resp_cout <= 1'b0;
      resp_ovf <= 1'b0;
      add_a <= '0;
      add_b <= '0;
      add_cin <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          gnt_q <= gnt;
          add_a <= sel_a;
          add_b <= sel_sub ? ~sel_b : sel_b;
          add_cin <= sel_sub;
          state <= EXEC;
        end
        EXEC: begin
          resp_sum <= add_s;
          resp_cout <= add_cout;
          resp_ovf <= add_ovf;
          resp_valid <= NUM_REQ'(1) << gnt_q;
          state <= RESP;
        end
        RESP: if (resp_ready[gnt_q]) begin
          resp_valid <= '0;
          rr_ptr <= wrap({1'b0, gnt_q} + (PW+1)'(1));
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: table, directed and random checks of adder_arbiter with a behavioural adder.
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] req_valid, req_ready, req_sub, resp_valid, resp_ready;
  logic [191:0] req_a, req_b;
  logic [63:0] resp_sum, add_a, add_b, add_s;
  logic resp_cout, resp_ovf, add_cin, add_cout, add_ovf, busy;
  int checks = 0;
  int failures = 0;
  int ptr = 0;
  logic [63:0] opa [3];
  logic [63:0] opb [3];
  bit ops [3];
  typedef struct {
    int idx;
    logic [63:0] a;
    logic [63:0] b;
    bit sub;
    logic [63:0] s;
    bit c;
    bit o;
  } vec_t;
  vec_t tab [6];

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 65'(add_cin);
  assign add_ovf = (add_a[63] == add_b[63]) && (add_s[63] != add_a[63]);

  adder_arbiter #(.NUM_REQ(3), .WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
    .resp_ovf(resp_ovf), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_ovf(add_ovf), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // A - B or A + B with carry as the unsigned no-borrow/wrap flag and ovf as signed range overflow.
  function automatic void ref_op(input logic [63:0] a, input logic [63:0] b, input bit sub,
                                 output logic [63:0] s, output bit c, output bit o);
    if (sub) begin
      s = a - b;
      c = a >= b;
      o = (a[63] != b[63]) && (s[63] != a[63]);
    end else begin
      s = a + b;
      c = s < a;
      o = (a[63] == b[63]) && (s[63] != a[63]);
    end
  endfunction

  task automatic issue(input logic [2:0] mask, input bit use_tab, input logic [63:0] ts,
                       input bit tc, input bit to, input int dly);
    int g;
    logic [63:0] es;
    bit ec, eo;
    g = -1;
    for (int k = 0; k < 3; k++)
      if (g < 0 && mask[(ptr + k) % 3]) g = (ptr + k) % 3;
    for (int i = 0; i < 3; i++) begin
      req_a[i*64 +: 64] = opa[i];
      req_b[i*64 +: 64] = opb[i];
      req_sub[i] = ops[i];
    end
    if (use_tab) begin
      es = ts; ec = tc; eo = to;
    end else ref_op(opa[g], opb[g], ops[g], es, ec, eo);
    req_valid = mask;
    resp_ready = (dly > 0) ? ~(3'b001 << g) : 3'b111;
    #1;
    chk("grant", req_ready, 64'(3'b001 << g));
    @(posedge clk); #1;
    req_valid = 3'b111;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    chk("exec_rv", resp_valid, 0);
    chk("add_a", add_a, opa[g]);
    chk("add_b", add_b, ops[g] ? ~opb[g] : opb[g]);
    chk("add_cin", add_cin, 64'(ops[g]));
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, 64'(3'b001 << g));
    chk("resp_sum", resp_sum, es);
    chk("resp_cout", resp_cout, 64'(ec));
    chk("resp_ovf", resp_ovf, 64'(eo));
    for (int d = 0; d < dly; d++) begin
      @(posedge clk); #1;
      chk("hold_rv", resp_valid, 64'(3'b001 << g));
      chk("hold_sum", resp_sum, es);
      chk("hold_flags", {resp_cout, resp_ovf}, 64'({ec, eo}));
      chk("hold_ready", req_ready, 0);
    end
    resp_ready = 3'b111;
    @(posedge clk); #1;
    req_valid = 3'b000;
    chk("done_busy", busy, 0);
    chk("done_rv", resp_valid, 0);
    ptr = (g + 1) % 3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ptr = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gcnt;
    int gidx [4];
    int gcyc [4];
    tab[0] = '{0, 64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0};
    tab[1] = '{1, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tab[2] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tab[3] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tab[4] = '{1, 64'h3, 64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tab[5] = '{2, 64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      opa[i] = 64'(i + 1); opb[i] = 64'(i + 2); ops[i] = 1'b0;
    end
    req_a = '0; req_b = '0; req_sub = '0; resp_ready = 3'b000;
    rst_n = 1'b0;
    req_valid = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_add", {add_a[0], add_b[0], add_cin}, 0);
    req_valid = 3'b000;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tab[i]) begin
      opa[tab[i].idx] = tab[i].a;
      opb[tab[i].idx] = tab[i].b;
      ops[tab[i].idx] = tab[i].sub;
      issue(3'b001 << tab[i].idx, 1'b1, tab[i].s, tab[i].c, tab[i].o, i % 2);
    end

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        opa[i] = {$urandom, $urandom};
        opb[i] = (n % 5 == 0) ? opa[i] : {$urandom, $urandom};
        ops[i] = 1'($urandom_range(0, 1));
      end
      issue(3'($urandom_range(1, 7)), 1'b0, 64'h0, 1'b0, 1'b0, $urandom_range(0, 2));
    end

    do_reset();
    req_valid = 3'b111;
    resp_ready = 3'b111;
    gcnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (req_ready != 3'b000 && gcnt < 4) begin
        gidx[gcnt] = (req_ready == 3'b001) ? 0 : (req_ready == 3'b010) ? 1 : (req_ready == 3'b100) ? 2 : -1;
        gcyc[gcnt] = cyc;
        gcnt++;
      end
      if (cyc == 10) req_valid = 3'b000;
      @(posedge clk); #1;
    end
    chk("rr_count", 64'(gcnt), 4);
    for (int i = 0; i < gcnt; i++) begin
      chk("rr_order", 64'(gidx[i]), 64'(i % 3));
      if (i > 0) chk("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 3);
    end
    chk("rr_idle", busy, 0);
    ptr = 1;

    opa[2] = 64'h1234; opb[2] = 64'h1; ops[2] = 1'b1;
    issue(3'b100, 1'b0, 64'h0, 1'b0, 1'b0, 5);

    opa[1] = 64'h10; opb[1] = 64'h20; ops[1] = 1'b0;
    issue(3'b010, 1'b0, 64'h0, 1'b0, 1'b0, 0);
    opa[1] = 64'hFFFF_FFFF_FFFF_FFFF; opb[1] = 64'h1; ops[1] = 1'b0;
    req_a[64 +: 64] = opa[1];
    req_b[64 +: 64] = opb[1];
    req_sub[1] = 1'b0;
    req_valid = 3'b010;
    @(posedge clk); #1;
    req_valid = 3'b000;
    chk("midop_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_rv", resp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midop_no_resp", resp_valid, 0);
    end
    req_valid = 3'b111;
    #1;
    chk("midop_first", req_ready, 3'b001);
    req_valid = 3'b000;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
